mips_alu_unit: RTL and testbench



---
 rtl/mips_alu_unit.sv | 172 +++++++++++++++++
 tb/tb_mips_alu_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_alu_unit.sv
// Execute-stage integer ALU for the 5-stage MIPS32 core.
// Computes arithmetic/logic/shift/LUI results, branch outcomes and signed
// overflow, passes the instruction ID through, and keeps sticky
// pass/fail/done flags written by MTC0 operations.
// Optional build macro ALU_OUT_REG_EN: registers every datapath output,
// which adds one cycle of latency. Without it the datapath is combinational.
module mips_alu_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [4:0]            in_alu_ctl,
  input  logic [DATA_WIDTH-1:0] in_op1,
  input  logic [DATA_WIDTH-1:0] in_op2,
  input  logic [ID_WIDTH-1:0]   instruction_id,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic                  out_branch_outcome,
  output logic                  out_overflow,
  output logic [ID_WIDTH-1:0]   instruction_id_out,
  output logic                  pass,
  output logic                  fail,
  output logic                  done
);

  localparam logic [4:0] OP_ADD   = 5'd1,  OP_ADDU = 5'd2,  OP_SUB  = 5'd3;
  localparam logic [4:0] OP_SUBU  = 5'd4,  OP_AND  = 5'd5,  OP_OR   = 5'd6;
  localparam logic [4:0] OP_XOR   = 5'd7,  OP_NOR  = 5'd8,  OP_SLT  = 5'd9;
  localparam logic [4:0] OP_SLTU  = 5'd10, OP_SLL  = 5'd11, OP_SRL  = 5'd12;
  localparam logic [4:0] OP_SRA   = 5'd13, OP_SLLV = 5'd14, OP_SRLV = 5'd15;
  localparam logic [4:0] OP_SRAV  = 5'd16, OP_LUI  = 5'd17, OP_BA   = 5'd18;
  localparam logic [4:0] OP_BEQ   = 5'd19, OP_BNE  = 5'd20, OP_BLEZ = 5'd21;
  localparam logic [4:0] OP_BGTZ  = 5'd22, OP_BGEZ = 5'd23, OP_BLTZ = 5'd24;
  localparam logic [4:0] OP_PASS  = 5'd25, OP_FAIL = 5'd26, OP_DONE = 5'd27;

  localparam int MSB = DATA_WIDTH - 1;

  logic signed [DATA_WIDTH-1:0] op1_s;
  logic signed [DATA_WIDTH-1:0] op2_s;
  logic        [4:0]            shamt;
  logic        [DATA_WIDTH-1:0] sum;
  logic        [DATA_WIDTH-1:0] diff;
  logic                         op1_zero;

  logic [DATA_WIDTH-1:0] result_d;
  logic                  branch_d;
  logic                  overflow_d;

  logic pass_d, fail_d, done_d;
  logic pass_q, fail_q, done_q;

  assign op1_s    = $signed(in_op1);
  assign op2_s    = $signed(in_op2);
  assign shamt    = in_op2[4:0];
  assign sum      = in_op1 + in_op2;
  assign diff     = in_op1 - in_op2;
  assign op1_zero = (in_op1 == '0);

  // Decode the operation into result, branch outcome and overflow; all zero when idle.
  always_comb begin
    result_d   = '0;
    branch_d   = 1'b0;
    overflow_d = 1'b0;
    if (in_valid) begin
      unique case (in_alu_ctl)
        OP_ADD: begin
          result_d   = sum;
          overflow_d = (in_op1[MSB] == in_op2[MSB]) && (sum[MSB] != in_op1[MSB]);
        end
        OP_ADDU: result_d = sum;
        OP_SUB: begin
          result_d   = diff;
          overflow_d = (in_op1[MSB] != in_op2[MSB]) && (diff[MSB] != in_op1[MSB]);
        end
        OP_SUBU:          result_d = diff;
        OP_AND:           result_d = in_op1 & in_op2;
        OP_OR:            result_d = in_op1 | in_op2;
        OP_XOR:           result_d = in_op1 ^ in_op2;
        OP_NOR:           result_d = ~(in_op1 | in_op2);
        OP_SLT:           result_d = {{MSB{1'b0}}, (op1_s < op2_s)};
        OP_SLTU:          result_d = {{MSB{1'b0}}, (in_op1 < in_op2)};
        OP_SLL, OP_SLLV:  result_d = in_op1 << shamt;
        OP_SRL, OP_SRLV:  result_d = in_op1 >> shamt;
        OP_SRA, OP_SRAV:  result_d = $unsigned(op1_s >>> shamt);
        OP_LUI:           result_d = {in_op2[15:0], 16'h0000};
        OP_BA:            branch_d = 1'b1;
        OP_BEQ:           branch_d = (in_op1 == in_op2);
        OP_BNE:           branch_d = (in_op1 != in_op2);
        OP_BLEZ:          branch_d = in_op1[MSB] | op1_zero;
        OP_BGTZ:          branch_d = ~in_op1[MSB] & ~op1_zero;
        OP_BGEZ:          branch_d = ~in_op1[MSB];
        OP_BLTZ:          branch_d = in_op1[MSB];
        default: ;
      endcase
    end
  end

  // Next state of the sticky flags; a recorded failure blocks any later pass.
  always_comb begin
    pass_d = pass_q;
    fail_d = fail_q;
    done_d = done_q;
    if (in_valid) begin
      unique case (in_alu_ctl)
        OP_PASS: if (!fail_q) pass_d = 1'b1;
        OP_FAIL: begin
          fail_d = 1'b1;
          pass_d = 1'b0;
        end
        OP_DONE: done_d = 1'b1;
        default: ;
      endcase
    end
  end

  // Sticky flag registers, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_q <= 1'b0;
      fail_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      pass_q <= pass_d;
      fail_q <= fail_d;
      done_q <= done_d;
    end
  end

  assign pass = pass_q;
  assign fail = fail_q;
  assign done = done_q;

`ifdef ALU_OUT_REG_EN
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  branch_q;
  logic                  overflow_q;
  logic [ID_WIDTH-1:0]   id_q;

  // Output register stage: one cycle of latency on every datapath output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      result_q   <= '0;
      branch_q   <= 1'b0;
      overflow_q <= 1'b0;
      id_q       <= '0;
    end else begin
      valid_q    <= in_valid;
      result_q   <= result_d;
      branch_q   <= branch_d;
      overflow_q <= overflow_d;
      id_q       <= instruction_id;
    end
  end

  assign out_valid          = valid_q;
  assign out_result         = result_q;
  assign out_branch_outcome = branch_q;
  assign out_overflow       = overflow_q;
  assign instruction_id_out = id_q;
`else
  assign out_valid          = in_valid;
  assign out_result         = result_d;
  assign out_branch_outcome = branch_d;
  assign out_overflow       = overflow_d;
  assign instruction_id_out = instruction_id;
`endif

endmodule

// File: tb/tb_mips_alu_unit.sv
// Testbench for mips_alu_unit: a behavioural model of the ALU rules checked
// against the DUT on every falling clock edge, plus directed literal vectors.
module tb_mips_alu_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [4:0]  in_alu_ctl = 5'd0;
  logic [31:0] in_op1 = 32'd0;
  logic [31:0] in_op2 = 32'd0;
  logic [19:0] instruction_id = 20'd0;
  logic        out_valid;
  logic [31:0] out_result;
  logic        out_branch_outcome;
  logic        out_overflow;
  logic [19:0] instruction_id_out;
  logic        pass, fail, done;

  int n_checks = 0;
  int n_fail   = 0;

  mips_alu_unit #(.DATA_WIDTH(32), .ID_WIDTH(20)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_alu_ctl(in_alu_ctl),
    .in_op1(in_op1), .in_op2(in_op2), .instruction_id(instruction_id),
    .out_valid(out_valid), .out_result(out_result),
    .out_branch_outcome(out_branch_outcome), .out_overflow(out_overflow),
    .instruction_id_out(instruction_id_out), .pass(pass), .fail(fail), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [31:0] r;
    logic        br;
    logic        ov;
    logic [19:0] id;
  } exp_t;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -SMAX - 64'sd1;

  // Behavioural model: plain 64-bit arithmetic on the operation's meaning.
  function automatic exp_t model(input logic v, input logic [4:0] c,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [19:0] id);
    exp_t e;
    longint sa, sb, ua, ub, t, d;
    int sh;
    e = '0;
    e.v = v;
    e.id = id;
    if (!v) return e;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sh = int'(b[4:0]);
    d  = longint'(1) << sh;
    case (c)
      5'd1, 5'd2: begin
        t = sa + sb; e.r = t[31:0];
        e.ov = (c == 5'd1) && (t > SMAX || t < SMIN);
      end
      5'd3, 5'd4: begin
        t = sa - sb; e.r = t[31:0];
        e.ov = (c == 5'd3) && (t > SMAX || t < SMIN);
      end
      5'd5: e.r = a & b;
      5'd6: e.r = a | b;
      5'd7: e.r = a ^ b;
      5'd8: e.r = ~(a | b);
      5'd9:  e.r = (sa < sb) ? 32'd1 : 32'd0;
      5'd10: e.r = (ua < ub) ? 32'd1 : 32'd0;
      5'd11, 5'd14: begin t = ua * d; e.r = t[31:0]; end
      5'd12, 5'd15: begin t = ua / d; e.r = t[31:0]; end
      5'd13, 5'd16: begin
        if (sa >= 0) t = sa / d;
        else t = -((-sa + d - 1) / d);
        e.r = t[31:0];
      end
      5'd17: begin t = longint'({48'd0, b[15:0]}) * 65536; e.r = t[31:0]; end
      5'd18: e.br = 1'b1;
      5'd19: e.br = (a == b);
      5'd20: e.br = (a != b);
      5'd21: e.br = (sa <= 0);
      5'd22: e.br = (sa > 0);
      5'd23: e.br = (sa >= 0);
      5'd24: e.br = (sa < 0);
      default: ;
    endcase
    return e;
  endfunction

  exp_t e_cmb, e_reg, e_chk;
  logic m_pass = 1'b0, m_fail = 1'b0, m_done = 1'b0;

  assign e_cmb = model(in_valid, in_alu_ctl, in_op1, in_op2, instruction_id);

  // Expected outputs one cycle later, for the registered-output build.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) e_reg <= '0;
    else        e_reg <= e_cmb;
  end

`ifdef ALU_OUT_REG_EN
  assign e_chk = e_reg;
`else
  assign e_chk = e_cmb;
`endif

  // Expected sticky flags.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pass <= 1'b0; m_fail <= 1'b0; m_done <= 1'b0;
    end else if (in_valid) begin
      if (in_alu_ctl == 5'd25 && !m_fail) m_pass <= 1'b1;
      if (in_alu_ctl == 5'd26) begin m_fail <= 1'b1; m_pass <= 1'b0; end
      if (in_alu_ctl == 5'd27) m_done <= 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Compare the DUT with the model on every falling edge.
  always @(negedge clk) begin
    chk("cmp_valid",  {31'd0, out_valid},          {31'd0, e_chk.v});
    chk("cmp_result", out_result,                  e_chk.r);
    chk("cmp_branch", {31'd0, out_branch_outcome}, {31'd0, e_chk.br});
    chk("cmp_ovf",    {31'd0, out_overflow},       {31'd0, e_chk.ov});
    chk("cmp_id",     {12'd0, instruction_id_out}, {12'd0, e_chk.id});
    chk("cmp_pass",   {31'd0, pass}, {31'd0, m_pass});
    chk("cmp_fail",   {31'd0, fail}, {31'd0, m_fail});
    chk("cmp_done",   {31'd0, done}, {31'd0, m_done});
  end

  // Apply one operation; returns once its outputs are visible.
  task automatic run(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                     input logic v, input logic [19:0] id);
    @(posedge clk);
    #1;
    in_valid = v; in_alu_ctl = c; in_op1 = a; in_op2 = b; instruction_id = id;
`ifdef ALU_OUT_REG_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  logic [31:0] va [8];
  logic [31:0] vb [8];

  initial begin
    va[0] = 32'h0;        vb[0] = 32'h0;
    va[1] = 32'h5;        vb[1] = 32'h5;
    va[2] = 32'h7FFFFFFF; vb[2] = 32'h1;
    va[3] = 32'h80000000; vb[3] = 32'h1;
    va[4] = 32'hFFFFFFFF; vb[4] = 32'h1;
    va[5] = 32'h80000000; vb[5] = 32'h4;
    va[6] = 32'h00001234; vb[6] = 32'hFFFF001F;
    va[7] = 32'hDEADBEEF; vb[7] = 32'h00000024;

    #1 rst_n = 1'b0;
    #1;
    chk("reset_pass", {31'd0, pass}, 32'd0);
    chk("reset_fail", {31'd0, fail}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    run(5'd1, 32'h7FFFFFFF, 32'h1, 1'b1, 20'h00001);
    chk("add_result", out_result, 32'h80000000);
    chk("add_ovf", {31'd0, out_overflow}, 32'd1);
    run(5'd2, 32'h7FFFFFFF, 32'h1, 1'b1, 20'h00002);
    chk("addu_result", out_result, 32'h80000000);
    chk("addu_ovf", {31'd0, out_overflow}, 32'd0);
    run(5'd9, 32'hFFFFFFFF, 32'h1, 1'b1, 20'h00003);
    chk("slt", out_result, 32'd1);
    run(5'd10, 32'hFFFFFFFF, 32'h1, 1'b1, 20'h00004);
    chk("sltu", out_result, 32'd0);
    run(5'd13, 32'h80000000, 32'h4, 1'b1, 20'h00005);
    chk("sra", out_result, 32'hF8000000);
    run(5'd12, 32'h80000000, 32'h4, 1'b1, 20'h00006);
    chk("srl", out_result, 32'h08000000);
    run(5'd17, 32'h0, 32'h1234, 1'b1, 20'h00007);
    chk("lui", out_result, 32'h12340000);
    run(5'd8, 32'h0, 32'h0, 1'b1, 20'h00008);
    chk("nor", out_result, 32'hFFFFFFFF);
    run(5'd6, 32'hFFFF0000, 32'h0000FFFF, 1'b0, 20'h00009);
    chk("invalid_result", out_result, 32'd0);
    chk("invalid_valid", {31'd0, out_valid}, 32'd0);
    run(5'd1, 32'h1, 32'h1, 1'b1, 20'hABCDE);
    chk("id_pass", {12'd0, instruction_id_out}, 32'h000ABCDE);
    run(5'd19, 32'h5, 32'h5, 1'b1, 20'h0000A);
    chk("beq", {31'd0, out_branch_outcome}, 32'd1);
    run(5'd20, 32'h5, 32'h5, 1'b1, 20'h0000B);
    chk("bne", {31'd0, out_branch_outcome}, 32'd0);
    run(5'd21, 32'h0, 32'h0, 1'b1, 20'h0000C);
    chk("blez", {31'd0, out_branch_outcome}, 32'd1);
    run(5'd22, 32'h80000000, 32'h0, 1'b1, 20'h0000D);
    chk("bgtz", {31'd0, out_branch_outcome}, 32'd0);
    run(5'd24, 32'h80000000, 32'h0, 1'b1, 20'h0000E);
    chk("bltz", {31'd0, out_branch_outcome}, 32'd1);
    run(5'd1, 32'h2, 32'h3, 1'b1, 20'h0000F);
    chk("add_2_3", out_result, 32'd5);

    for (int c = 0; c < 32; c++) begin
      if (c >= 25 && c <= 27) continue;
      for (int k = 0; k < 8; k++)
        run(5'(c), va[k], vb[k], 1'b1, 20'(c * 8 + k));
    end

    run(5'd25, 32'h0, 32'h0, 1'b1, 20'h00100);
    @(posedge clk); #1;
    chk("flag_pass_set", {31'd0, pass}, 32'd1);
    run(5'd27, 32'h0, 32'h0, 1'b1, 20'h00101);
    @(posedge clk); #1;
    chk("flag_done_set", {31'd0, done}, 32'd1);
    chk("flag_pass_kept", {31'd0, pass}, 32'd1);
    run(5'd26, 32'h0, 32'h0, 1'b1, 20'h00102);
    @(posedge clk); #1;
    chk("flag_fail_set", {31'd0, fail}, 32'd1);
    chk("flag_pass_clr", {31'd0, pass}, 32'd0);
    run(5'd25, 32'h0, 32'h0, 1'b1, 20'h00103);
    @(posedge clk); #1;
    chk("flag_pass_blocked", {31'd0, pass}, 32'd0);

    run(5'd1, 32'h2, 32'h3, 1'b1, 20'h00104);
    #1 rst_n = 1'b0;
    #1;
    chk("async_pass", {31'd0, pass}, 32'd0);
    chk("async_fail", {31'd0, fail}, 32'd0);
    chk("async_done", {31'd0, done}, 32'd0);
`ifdef ALU_OUT_REG_EN
    chk("async_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_out_result", out_result, 32'd0);
`else
    chk("async_out_valid", {31'd0, out_valid}, 32'd1);
    chk("async_out_result", out_result, 32'd5);
`endif
    @(negedge clk); #2 rst_n = 1'b1;
    run(5'd0, 32'h0, 32'h0, 1'b0, 20'h0);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
